// File: rtl/clarvi_wide_writeback.sv
// clarvi_wide_writeback
//   Write-back sequencer in front of the Clarvi register-file write port.
//   It queues 64-bit results with a per-half write mask in a small FIFO.
//   For each queued result it issues one 32-bit register-file write per
//   selected half, low half first. It also flags decode source registers
//   that still have writes in flight.
//
// Ports
//   clock, reset              : clock; asynchronous active-high reset
//   in_valid/in_ready         : request handshake (in_ready = FIFO not full)
//   in_register/data/mask     : destination, 64-bit result, {hi,lo} write mask
//   rf_write_*                : registered register-file write port
//   query_register_1/2        : decode source registers
//   hazard_1/2                : combinational pending-write flags
//   idle                      : FIFO empty and no write in progress
module clarvi_wide_writeback #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_register,
  input  logic [63:0] in_data,
  input  logic [1:0]  in_mask,
  output logic        rf_write_enable,
  output logic        rf_write_part,
  output logic [4:0]  rf_write_register,
  output logic [31:0] rf_write_data,
  input  logic [4:0]  query_register_1,
  input  logic [4:0]  query_register_2,
  output logic        hazard_1,
  output logic        hazard_2,
  output logic        idle
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;

  state_t        state, next_state;
  logic          hi_pending, next_hi_pending;
  logic [4:0]    cur_reg, next_reg;
  logic [63:0]   cur_data, next_data;

  logic [4:0]    fifo_reg  [DEPTH];
  logic [63:0]   fifo_data [DEPTH];
  logic [1:0]    fifo_mask [DEPTH];
  logic [DEPTH-1:0] fifo_valid;
  logic [PW-1:0] rd_ptr, wr_ptr;

  logic empty, full, push, pop;

  // Per-slot valid bits: the head slot is empty only when the FIFO is empty,
  // and the tail slot is occupied only when the FIFO is full.
  assign empty    = !fifo_valid[rd_ptr];
  assign full     = fifo_valid[wr_ptr];
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign idle     = empty && (state == IDLE);

  always_comb begin
    next_state      = IDLE;
    next_hi_pending = 1'b0;
    next_reg        = cur_reg;
    next_data       = cur_data;
    pop             = 1'b0;
    if (state == WR_LO && hi_pending) begin
      next_state = WR_HI;
    end else if (!empty) begin
      pop = 1'b1;
      if (fifo_reg[rd_ptr] != '0 && fifo_mask[rd_ptr][0]) begin
        next_state      = WR_LO;
        next_hi_pending = fifo_mask[rd_ptr][1];
        next_reg        = fifo_reg[rd_ptr];
        next_data       = fifo_data[rd_ptr];
      end else if (fifo_reg[rd_ptr] != '0 && fifo_mask[rd_ptr][1]) begin
        next_state = WR_HI;
        next_reg   = fifo_reg[rd_ptr];
        next_data  = fifo_data[rd_ptr];
      end
      // x0 or an empty mask: the entry is consumed with no write.
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      hi_pending        <= 1'b0;
      cur_reg           <= '0;
      cur_data          <= '0;
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      fifo_valid        <= '0;
      rf_write_enable   <= 1'b0;
      rf_write_part     <= 1'b0;
      rf_write_register <= '0;
      rf_write_data     <= '0;
    end else begin
      state      <= next_state;
      hi_pending <= next_hi_pending;
      cur_reg    <= next_reg;
      cur_data   <= next_data;
      // Pop and push never target the same slot: a pop needs a non-empty
      // FIFO and a push a non-full one, so the pointers differ.
      if (pop) begin
        fifo_valid[rd_ptr] <= 1'b0;
        rd_ptr             <= rd_ptr + PW'(1);
      end
      if (push) begin
        fifo_valid[wr_ptr] <= 1'b1;
        wr_ptr             <= wr_ptr + PW'(1);
      end
      // Output registers follow the state being entered.
      case (next_state)
        WR_LO: begin
          rf_write_enable   <= 1'b1;
          rf_write_part     <= 1'b0;
          rf_write_register <= next_reg;
          rf_write_data     <= next_data[31:0];
        end
        WR_HI: begin
          rf_write_enable   <= 1'b1;
          rf_write_part     <= 1'b1;
          rf_write_register <= next_reg;
          rf_write_data     <= next_data[63:32];
        end
        default: rf_write_enable <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_reg[wr_ptr]  <= in_register;
      fifo_data[wr_ptr] <= in_data;
      fifo_mask[wr_ptr] <= in_mask;
    end
  end

  // The current entry stays a hazard through its final write cycle because
  // the register file only captures that write at the closing edge.
  always_comb begin
    hazard_1 = 1'b0;
    hazard_2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fifo_valid[i] && fifo_mask[i] != 2'b00) begin
        if (fifo_reg[i] == query_register_1) hazard_1 = 1'b1;
        if (fifo_reg[i] == query_register_2) hazard_2 = 1'b1;
      end
    end
    if (state != IDLE) begin
      if (cur_reg == query_register_1) hazard_1 = 1'b1;
      if (cur_reg == query_register_2) hazard_2 = 1'b1;
    end
    if (query_register_1 == '0) hazard_1 = 1'b0;
    if (query_register_2 == '0) hazard_2 = 1'b0;
  end

endmodule

// File: doc/clarvi_wide_writeback.md
# clarvi_wide_writeback

Write-back sequencer that sits directly upstream of the Clarvi register file's write port. It accepts 64-bit results with a per-half write mask and buffers them in a small FIFO. It then issues one 32-bit register-file write per selected half: low half first, then high half. It also exports a pending-write scoreboard so that decode can stall on registers with writes still in flight.

## Interface

- DEPTH, 2: request FIFO entries; power of two, ≥2.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  write-back request present.
- in_ready  out  1  FIFO can accept; equals !full.
- in_register  in  5  destination register.
- in_data  in  64  result; [31:0] is the low part, [63:32] is the high part.
- in_mask  in  2  bit0: write low part; bit1: write high part.
- rf_write_enable  out  1  registered; drives register-file write_enable.
- rf_write_part  out  1  registered; 0 = low, 1 = high.
- rf_write_register  out  5  registered.
- rf_write_data  out  32  registered; drives register-file data_in.
- query_register_1  in  5  decode source register 1.
- query_register_2  in  5  decode source register 2.
- hazard_1  out  1  combinational; query_register_1 has a pending write.
- hazard_2  out  1  combinational; same for query_register_2.
- idle  out  1  FIFO empty and engine in IDLE.

## Operation

- Push: a request is accepted on a rising edge where in_valid && in_ready. There is no same-cycle bypass, so a request is never written in the cycle it is accepted.
- The engine holds one current entry: register, data, and a high-pending flag.
- States:
  - IDLE: no write issued.
  - WR_LO: low part driven.
  - WR_HI: high part driven.
- Transitions, evaluated at each edge in priority order:
  1. If state is WR_LO and high-pending, go to WR_HI. The FIFO is not popped.
  2. Otherwise, if the FIFO is non-empty, pop the head:
     - If the register is non-zero and mask[0] is set, go to WR_LO. Set high-pending = mask[1].
     - Otherwise, if the register is non-zero and mask[1] is set, go to WR_HI.
     - Otherwise (mask 2'b00, or register 0), drop the entry, go to IDLE, and issue no write.
  3. Otherwise, go to IDLE.
- Output registers:
  - In WR_LO: rf_write_enable=1, part=0, data=cur_data[31:0].
  - In WR_HI: rf_write_enable=1, part=1, data=cur_data[63:32].
  - In IDLE: rf_write_enable=0. Part, register and data hold their last values.
- A single-part write leaves the other part of the register unchanged. The register file merges the other part itself.
- Hazard: hazard_n=1 if query_register_n≠0 and it matches either of these:
  - any valid FIFO entry with a non-zero mask;
  - the current entry while state≠IDLE. This includes the final write cycle, because the write lands only at the end of that cycle.
- Multiple pending entries for the same register are allowed. They are written in order.
- FIFO full: in_ready=0. A pop and a push can never coincide while full. A pop and a push in the same edge while not full is legal, and the count is unchanged.

## Timing

- Reset asserted, immediate and asynchronous:
  - FIFO is emptied, state=IDLE, high-pending=0.
  - rf_write_enable=0, rf_write_part=0, rf_write_register=0, rf_write_data=0.
  - in_ready=1 and idle=1.
  - hazard_1=hazard_2=0.
- Latency, for a request accepted at edge E into an empty, idle block:
  - Mask 2'b11: WR_LO is output after E+1 and the register file captures it at E+2. WR_HI is output after E+2 and captured at E+3. The block is idle again after E+3, unless more requests are queued.
  - Single-part mask: written at E+2.
  - Dropped request: consumed at E+1 with no write.
- Throughput: one register-file write per cycle, so back-to-back full-width requests take 2 cycles each.
- in_ready follows the registered count. A slot freed by the pop at edge N is visible after N.
- Reset mid-operation aborts the in-flight write.
  - A register whose low part was already captured keeps its new low part and its old high part.
  - Queued requests are lost.

## Test plan

- Single full write: push reg 5, data 0x1111_2222_3333_4444, mask 2'b11 at E → WR_LO output (part 0, data 0x3333_4444) after E+1; WR_HI output (part 1, data 0x1111_2222) after E+2; idle=1 after E+3.
- Masks and x0 are suppressed, with one push of each:
  - reg 7 mask 2'b10 → a single high write of data[63:32].
  - reg 0 mask 2'b11 → no rf_write_enable pulse.
  - reg 9 mask 2'b00 → no write; hazard on 9 is never asserted.
- Backpressure with DEPTH=2: push three full-width requests with in_valid held high → in_ready drops when the FIFO is full; all three are written in order, six write cycles in total, with no lost or duplicated part.
- Hazard: push reg 12, full width; query_register_1=12 → hazard_1=1 from the cycle after acceptance through the WR_HI cycle, and 0 the cycle after; query 0 → hazard always 0.
- Same-register ordering: push reg 3 data A, then reg 3 data B → the register file ends holding B; hazard stays high until B's last part is written.
- Reset mid-write: assert reset during WR_HI with one entry queued → outputs clear immediately; after release nothing further is written and idle=1.
